// File: rtl/bram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter_if
//   Bundles the three buses around the BRAM port-B arbiter:
//     cpu_*   CPU data-side BRAM access (request, strobes, address, data)
//     dma_*   DMA/loader master access with grant, read-valid and error
//     bram_*  BRAM port-B enable, strobes, address, write/read data
//     contention_cnt_o  saturating count of CPU contention stall cycles
//   Modports:
//     slave   the arbiter's view (takes CPU/DMA requests, drives the BRAM)
//     master  the surrounding system's view (CPU, DMA and BRAM together)
// ---------------------------------------------------------------------------
interface bram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  cpu_enable_i;
    logic [3:0]            cpu_write_enable_i;
    logic [ADDR_WIDTH-1:0] cpu_address_i;
    logic [31:0]           cpu_data_i;
    logic [31:0]           cpu_data_o;
    logic                  cpu_stall_o;

    logic                  dma_req_i;
    logic [3:0]            dma_we_i;
    logic [ADDR_WIDTH-1:0] dma_address_i;
    logic [31:0]           dma_data_i;
    logic                  dma_gnt_o;
    logic                  dma_rvalid_o;
    logic [31:0]           dma_data_o;
    logic                  dma_err_o;

    logic                  bram_en_o;
    logic [3:0]            bram_we_o;
    logic [ADDR_WIDTH-1:0] bram_addr_o;
    logic [31:0]           bram_data_o;
    logic [31:0]           bram_data_i;

    logic [CNT_WIDTH-1:0]  contention_cnt_o;

    modport slave (
        input  cpu_enable_i, cpu_write_enable_i, cpu_address_i, cpu_data_i,
        output cpu_data_o, cpu_stall_o,
        input  dma_req_i, dma_we_i, dma_address_i, dma_data_i,
        output dma_gnt_o, dma_rvalid_o, dma_data_o, dma_err_o,
        output bram_en_o, bram_we_o, bram_addr_o, bram_data_o,
        input  bram_data_i,
        output contention_cnt_o
    );

    modport master (
        output cpu_enable_i, cpu_write_enable_i, cpu_address_i, cpu_data_i,
        input  cpu_data_o, cpu_stall_o,
        output dma_req_i, dma_we_i, dma_address_i, dma_data_i,
        input  dma_gnt_o, dma_rvalid_o, dma_data_o, dma_err_o,
        input  bram_en_o, bram_we_o, bram_addr_o, bram_data_o,
        output bram_data_i,
        input  contention_cnt_o
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//   Shares BRAM port B between the CPU data interface and one DMA/loader
//   master. Round-robin on contention, combinational grant in the request
//   cycle, 1-cycle read-response routing, CPU stall on loss, and a
//   saturating contention-stall counter for profiling.
//   Ports:
//     clk    rising-edge system clock
//     reset  synchronous, active-high
//     bus    bram_port_arbiter_if.slave (CPU, DMA and BRAM buses)
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BRAM_BASE  = '0,
    parameter logic [ADDR_WIDTH-1:0] BRAM_LIMIT = ADDR_WIDTH'(32'h0000_FFFF),
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input logic                  clk,
    input logic                  reset,
    bram_port_arbiter_if.slave   bus
);

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DMA = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_CPU  = 2'd1,
        RSP_DMA  = 2'd2
    } rsp_e;

    grant_e               last_grant_q, last_grant_d;
    rsp_e                 rsp_owner_q, rsp_owner_d;
    logic [31:0]          cpu_data_q;
    logic [31:0]          dma_data_q;
    logic                 dma_err_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic dma_in_range;
    logic cpu_req;
    logic dma_req_ok;
    logic dma_req_bad;
    logic cpu_gnt;
    logic dma_gnt;
    logic cpu_stall;
    logic rsp_live;

    // Single unsigned compare: addresses below BRAM_BASE wrap to huge
    // offsets and fall outside the window without a second comparator.
    assign dma_in_range = (bus.dma_address_i - BRAM_BASE) <= (BRAM_LIMIT - BRAM_BASE);

    // Reset masks every request so nothing is granted while it is held.
    assign cpu_req     = bus.cpu_enable_i & ~reset;
    assign dma_req_ok  = bus.dma_req_i &  dma_in_range & ~reset;
    assign dma_req_bad = bus.dma_req_i & ~dma_in_range & ~reset;

    // CPU wins unless a valid DMA request contends and the CPU was the
    // last one served.
    assign cpu_gnt   = cpu_req & (~dma_req_ok | (last_grant_q == GRANT_DMA));
    assign dma_gnt   = dma_req_ok & ~cpu_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Next-state logic for the grant history and the response tracker.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        last_grant_d = last_grant_q;
        rsp_owner_d  = RSP_NONE;
        if (cpu_gnt) begin
            last_grant_d = GRANT_CPU;
            if (bus.cpu_write_enable_i == 4'h0) rsp_owner_d = RSP_CPU;
        end else if (dma_gnt) begin
            last_grant_d = GRANT_DMA;
            if (bus.dma_we_i == 4'h0) rsp_owner_d = RSP_DMA;
        end
    end

    // BRAM port mux: winner drives the port, idle port is all zeros.
    always_comb begin
        bus.bram_en_o   = 1'b0;
        bus.bram_we_o   = 4'h0;
        bus.bram_addr_o = '0;
        bus.bram_data_o = 32'h0;
        if (cpu_gnt) begin
            bus.bram_en_o   = 1'b1;
            bus.bram_we_o   = bus.cpu_write_enable_i;
            bus.bram_addr_o = bus.cpu_address_i;
            bus.bram_data_o = bus.cpu_data_i;
        end else if (dma_gnt) begin
            bus.bram_en_o   = 1'b1;
            bus.bram_we_o   = bus.dma_we_i;
            bus.bram_addr_o = bus.dma_address_i;
            bus.bram_data_o = bus.dma_data_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            last_grant_q <= GRANT_DMA;
            rsp_owner_q  <= RSP_NONE;
            cpu_data_q   <= 32'h0;
            dma_data_q   <= 32'h0;
            dma_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_owner_q  <= rsp_owner_d;
            if (rsp_owner_q == RSP_CPU) cpu_data_q <= bus.bram_data_i;
            if (rsp_owner_q == RSP_DMA) dma_data_q <= bus.bram_data_i;
            dma_err_q    <= dma_req_bad;
            if (cpu_stall && !(&cnt_q)) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // A read in flight when reset arrives must not surface as a response.
    assign rsp_live = ~reset;

    assign bus.cpu_data_o       = (rsp_live && rsp_owner_q == RSP_CPU) ? bus.bram_data_i : cpu_data_q;
    assign bus.cpu_stall_o      = cpu_stall;
    assign bus.dma_gnt_o        = dma_gnt | dma_req_bad;
    assign bus.dma_rvalid_o     = rsp_live && (rsp_owner_q == RSP_DMA);
    assign bus.dma_data_o       = (rsp_live && rsp_owner_q == RSP_DMA) ? bus.bram_data_i : dma_data_q;
    assign bus.dma_err_o        = dma_err_q;
    assign bus.contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//   Directed stimulus against bram_port_arbiter with a 1-cycle-latency BRAM
//   model. Read responses and error pulses are queued when the request is
//   issued; a monitor on the falling edge pops and compares them whenever
//   the DUT presents a response.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    bram_port_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dma_q[$];
    int   err_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: registered read, byte-strobed write.
    logic [31:0] mem [0:1023];
    logic [31:0] wword;
    always @(posedge clk) begin
        if (bus.bram_en_o) begin
            if (bus.bram_we_o == 4'h0) begin
                bus.bram_data_i <= mem[bus.bram_addr_o[11:2]];
            end else begin
                wword = mem[bus.bram_addr_o[11:2]];
                for (int b = 0; b < 4; b++)
                    if (bus.bram_we_o[b]) wword[8*b +: 8] = bus.bram_data_o[8*b +: 8];
                mem[bus.bram_addr_o[11:2]] <= wword;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle with the given requests; returns at the falling edge.
    task automatic drive(input logic ce, input logic [3:0] cwe, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr, input logic [3:0] dwe,
                         input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        bus.cpu_enable_i       = ce;
        bus.cpu_write_enable_i = cwe;
        bus.cpu_address_i      = ca;
        bus.cpu_data_i         = cd;
        bus.dma_req_i          = dr;
        bus.dma_we_i           = dwe;
        bus.dma_address_i      = da;
        bus.dma_data_i         = dd;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic clear_inputs();
        bus.cpu_enable_i       = 1'b0;
        bus.cpu_write_enable_i = 4'h0;
        bus.cpu_address_i      = 32'h0;
        bus.cpu_data_i         = 32'h0;
        bus.dma_req_i          = 1'b0;
        bus.dma_we_i           = 4'h0;
        bus.dma_address_i      = 32'h0;
        bus.dma_data_i         = 32'h0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cpu_data"},   bus.cpu_data_o,       32'h0);
        check({tag, "_dma_data"},   bus.dma_data_o,       32'h0);
        check({tag, "_dma_rvalid"}, bus.dma_rvalid_o,     32'h0);
        check({tag, "_dma_err"},    bus.dma_err_o,        32'h0);
        check({tag, "_cnt"},        bus.contention_cnt_o, 32'h0);
    endtask

    // Response monitor.
    initial begin : monitor
        exp_t e;
        int   ec;
        forever begin
            @(negedge clk);
            if (bus.dma_rvalid_o) begin
                if (dma_q.size() == 0) begin
                    check("dma_rvalid_spurious", bus.dma_rvalid_o, 32'h0);
                end else begin
                    e = dma_q.pop_front();
                    check("dma_rvalid_cycle", cyc, e.cyc);
                    check("dma_rdata", bus.dma_data_o, e.data);
                end
            end else if (dma_q.size() > 0 && dma_q[0].cyc <= cyc) begin
                e = dma_q.pop_front();
                check("dma_rvalid_missing", bus.dma_rvalid_o, 32'h1);
            end
            if (cpu_q.size() > 0 && cpu_q[0].cyc <= cyc) begin
                e = cpu_q.pop_front();
                check("cpu_rdata", bus.cpu_data_o, e.data);
            end
            if (bus.dma_err_o) begin
                if (err_q.size() == 0) begin
                    check("dma_err_spurious", bus.dma_err_o, 32'h0);
                end else begin
                    ec = err_q.pop_front();
                    check("dma_err_cycle", cyc, ec);
                end
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                ec = err_q.pop_front();
                check("dma_err_missing", bus.dma_err_o, 32'h1);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] t3_stall;
        logic       stall_exp;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[64] = 32'hDEAD_BEEF;          // byte address 0x100
        clear_inputs();
        reset = 1'b1;

        // Requests during reset are never granted.
        drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        check("rst_bram_en",   bus.bram_en_o,   32'h0);
        check("rst_dma_gnt",   bus.dma_gnt_o,   32'h0);
        check("rst_cpu_stall", bus.cpu_stall_o, 32'h0);
        clear_inputs();
        reset = 1'b0;
        idle();
        check_reset_state("por");

        // CPU read, uncontended.
        drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("t1_bram_en",   bus.bram_en_o,   32'h1);
        check("t1_cpu_stall", bus.cpu_stall_o, 32'h0);
        check("t1_bram_addr", bus.bram_addr_o, 32'h100);
        check("t1_bram_we",   bus.bram_we_o,   32'h0);
        cpu_q.push_back('{cyc + 1, 32'hDEAD_BEEF});
        idle();
        idle();
        check("t1_cpu_data_hold", bus.cpu_data_o, 32'hDEAD_BEEF);

        // DMA write, then CPU reads it back.
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h200, 32'h1234_5678);
        check("t2_dma_gnt",   bus.dma_gnt_o,   32'h1);
        check("t2_bram_we",   bus.bram_we_o,   32'hF);
        check("t2_bram_addr", bus.bram_addr_o, 32'h200);
        check("t2_bram_data", bus.bram_data_o, 32'h1234_5678);
        check("t2_cpu_stall", bus.cpu_stall_o, 32'h0);
        idle();
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        cpu_q.push_back('{cyc + 1, 32'h1234_5678});
        idle();
        idle();

        // Reset, then four cycles of contention: CPU, DMA, CPU, DMA.
        reset = 1'b1;
        idle();
        reset = 1'b0;
        t3_stall = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
            check("t3_cpu_stall", bus.cpu_stall_o, {31'h0, t3_stall[k]});
            check("t3_dma_gnt",   bus.dma_gnt_o,   {31'h0, t3_stall[k]});
            check("t3_bram_addr", bus.bram_addr_o, t3_stall[k] ? 32'h200 : 32'h100);
            if (t3_stall[k]) dma_q.push_back('{cyc + 1, 32'h1234_5678});
            else             cpu_q.push_back('{cyc + 1, 32'hDEAD_BEEF});
        end
        idle();
        check("t3_contention_cnt", bus.contention_cnt_o, 32'h2);

        // Out-of-range DMA: accepted, errored, never touches BRAM or blocks CPU.
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
        check("t4_dma_gnt", bus.dma_gnt_o, 32'h1);
        check("t4_bram_en", bus.bram_en_o, 32'h0);
        err_q.push_back(cyc + 1);
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
        check("t4b_dma_gnt",   bus.dma_gnt_o,   32'h1);
        check("t4b_cpu_stall", bus.cpu_stall_o, 32'h0);
        check("t4b_bram_addr", bus.bram_addr_o, 32'h200);
        err_q.push_back(cyc + 1);
        cpu_q.push_back('{cyc + 1, 32'h1234_5678});
        idle();
        check("t4_contention_cnt", bus.contention_cnt_o, 32'h2);
        idle();

        // DMA read granted, reset next cycle: response is dropped.
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        check("t5_dma_gnt", bus.dma_gnt_o, 32'h1);
        check("t5_bram_en", bus.bram_en_o, 32'h1);
        clear_inputs();
        reset = 1'b1;
        idle();
        check("t5_rvalid_in_reset", bus.dma_rvalid_o, 32'h0);
        reset = 1'b0;
        idle();
        check_reset_state("t5");
        drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        check("t5_first_cpu_stall", bus.cpu_stall_o, 32'h0);
        check("t5_first_dma_gnt",   bus.dma_gnt_o,   32'h0);
        cpu_q.push_back('{cyc + 1, 32'hDEAD_BEEF});
        drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        check("t5_second_cpu_stall", bus.cpu_stall_o, 32'h1);
        check("t5_second_dma_gnt",   bus.dma_gnt_o,   32'h1);
        dma_q.push_back('{cyc + 1, 32'h1234_5678});

        // Continuous contention: 1 stall so far plus 20 more saturates at 15.
        for (int k = 0; k < 40; k++) begin
            stall_exp = (k % 2) == 1;
            drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
            check("t6_cpu_stall", bus.cpu_stall_o, {31'h0, stall_exp});
            if (stall_exp) dma_q.push_back('{cyc + 1, 32'h1234_5678});
            else           cpu_q.push_back('{cyc + 1, 32'hDEAD_BEEF});
        end
        idle();
        check("t6_cnt_saturated", bus.contention_cnt_o, 32'hF);
        idle();
        idle();
        check("scoreboard_drain", cpu_q.size() + dma_q.size() + err_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the BRAM data port (port B) between the CPU data interface and one DMA/loader master.
- Sits between the CPU and the BRAM in the SoC top, after the BRAM/peripheral address decode. Only BRAM-range CPU accesses reach this block.
- Applies round-robin arbitration with a 1-cycle BRAM read-latency response tracker, and raises CPU stall on contention.
- Counts CPU stall cycles caused by contention, for profiling.

Parameters:
- ADDR_WIDTH, 32, width of all address ports
- BRAM_BASE, 32'h0000_0000, lowest valid BRAM byte address for DMA
- BRAM_LIMIT, 32'h0000_FFFF, highest valid BRAM byte address for DMA
- CNT_WIDTH, 16, width of the contention counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_enable_i  in  1  CPU BRAM access request (already range-decoded)
- cpu_write_enable_i  in  4  CPU byte write strobes; 0 means read
- cpu_address_i  in  ADDR_WIDTH  CPU byte address
- cpu_data_i  in  32  CPU write data
- cpu_data_o  out  32  CPU read data
- cpu_stall_o  out  1  CPU must hold its request; not granted this cycle
- dma_req_i  in  1  DMA access request
- dma_we_i  in  4  DMA byte write strobes; 0 means read
- dma_address_i  in  ADDR_WIDTH  DMA byte address
- dma_data_i  in  32  DMA write data
- dma_gnt_o  out  1  DMA request accepted this cycle
- dma_rvalid_o  out  1  dma_data_o valid (1-cycle pulse)
- dma_data_o  out  32  DMA read data
- dma_err_o  out  1  DMA address out of range (1-cycle pulse)
- bram_en_o  out  1  BRAM port enable
- bram_we_o  out  4  BRAM byte write enables
- bram_addr_o  out  ADDR_WIDTH  BRAM address
- bram_data_o  out  32  BRAM write data
- bram_data_i  in  32  BRAM read data (registered, 1-cycle latency)
- contention_cnt_o  out  CNT_WIDTH  saturating count of contention stall cycles

Behaviour:
- The grant decision is combinational in the request cycle; the BRAM samples at the next rising edge.
- A DMA request is "valid" when dma_req_i=1 and BRAM_BASE <= dma_address_i <= BRAM_LIMIT.
- Arbitration:
  - CPU only → CPU granted.
  - Valid DMA only → DMA granted.
  - Both → the requester not granted last time wins.
  - Register last_grant updates only on a real BRAM grant. Its reset value is DMA, so the CPU wins the first contention.
- BRAM mux: bram_en_o=1 on any grant. bram_we_o, bram_addr_o and bram_data_o come from the winner. With no grant, everything is 0.
- Stall: cpu_stall_o = cpu_enable_i & ~cpu_granted, purely combinational. The CPU holds its address, data and strobes stable while stalled.
- dma_gnt_o:
  - 1 when DMA is granted, or when dma_req_i=1 with an out-of-range address (accepted and errored).
  - The DMA master holds its request until dma_gnt_o=1.
- Out-of-range DMA: no BRAM access, last_grant unchanged, dma_err_o=1 in the following cycle. It never blocks the CPU.
- Response tracking: register rsp_owner ∈ {NONE, CPU, DMA}. It is set to the granted reader when the grant has write strobes = 0, and NONE otherwise.
  - Next cycle with rsp_owner=DMA: dma_rvalid_o=1 and dma_data_o=bram_data_i.
  - cpu_data_o = bram_data_i whenever rsp_owner=CPU. Otherwise it holds its last captured value, via a register updated only on CPU response cycles.
- Writes produce no response pulse.
- Back-to-back grants are allowed every cycle. A response and a new grant may coincide.
- contention_cnt_o increments when cpu_stall_o=1, saturates at all-ones, and never wraps.
- Reset values: last_grant=DMA, rsp_owner=NONE, cpu_data_o=0, dma_data_o=0, dma_rvalid_o=0, dma_err_o=0, contention_cnt_o=0.
  - Combinational outputs follow the inputs during reset but grant nothing: bram_en_o=0, dma_gnt_o=0, cpu_stall_o=0.
- Reset asserted with a read in flight: the response pulse is suppressed in the cycle after reset.

Test Plan:
- CPU read at 0x0000_0100 only, BRAM word 0xDEADBEEF → bram_en_o=1 and cpu_stall_o=0 in cycle 0; cpu_data_o=0xDEADBEEF in cycle 1.
- DMA write of 0x12345678 with we=4'hF to 0x0000_0200 → dma_gnt_o=1 in the same cycle with bram_we_o=4'hF; no rvalid follows; a later CPU read returns 0x12345678.
- CPU and DMA request together for 4 cycles straight after reset → grants go CPU, DMA, CPU, DMA; cpu_stall_o=1 in cycles 1 and 3; contention_cnt_o=2.
- DMA read at 0x0001_0000 → dma_gnt_o=1, bram_en_o=0, dma_err_o=1 next cycle, no rvalid; a simultaneous CPU request is granted without stall.
- DMA read grant followed by reset in the next cycle → dma_rvalid_o stays 0, all registered outputs are 0, and the next contention goes to the CPU.
- Force continuous contention with CNT_WIDTH=4 → contention_cnt_o saturates at 15.
